// File: rtl/rat_reg_file.sv
// General-purpose register file for the RAT CPU: two combinational read ports
// and one synchronous write port that shares its address with read port X.
module rat_reg_file #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] DIN,
  input  logic [ADDR_W-1:0] ADRX,
  input  logic [ADDR_W-1:0] ADRY,
  input  logic              RF_WR,
  output logic [DATA_W-1:0] DX_OUT,
  output logic [DATA_W-1:0] DY_OUT
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  // Reset wins over a write on the same edge; only the addressed entry changes otherwise.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (RF_WR) begin
      regs[ADRX] <= DIN;
    end
  end

  // Reads come straight from storage, so a write shows up only after its edge.
  assign DX_OUT = regs[ADRX];
  assign DY_OUT = regs[ADRY];

endmodule

// File: tb/tb_rat_reg_file.sv
// Directed bench for rat_reg_file: expected read data is queued as stimulus is
// applied and compared against the read ports once they settle.
module tb_rat_reg_file;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic [4:0] adrx;
  logic [4:0] adry;
  logic       rf_wr;
  logic [7:0] dx_out;
  logic [7:0] dy_out;

  logic [7:0] exp_q[$];
  int total;
  int bad;

  rat_reg_file dut (
    .CLK    (clk),
    .RST    (rst),
    .DIN    (din),
    .ADRX   (adrx),
    .ADRY   (adry),
    .RF_WR  (rf_wr),
    .DX_OUT (dx_out),
    .DY_OUT (dy_out)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_xy(input logic [7:0] x, input logic [7:0] y);
    exp_q.push_back(x);
    exp_q.push_back(y);
  endtask

  // Scoreboard: pops an X/Y pair and compares against the read ports
  task automatic check_xy(input string tag);
    logic [7:0] ex;
    logic [7:0] ey;
    #1;
    total++;
    if (exp_q.size() < 2) begin
      bad++;
      $error("FAIL %s: scoreboard empty, dx=%h dy=%h", tag, dx_out, dy_out);
    end else begin
      ex = exp_q.pop_front();
      ey = exp_q.pop_front();
      assert (dx_out === ex && dy_out === ey) else begin
        bad++;
        $error("FAIL %s: got dx=%h dy=%h expected dx=%h dy=%h", tag, dx_out, dy_out, ex, ey);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    din   = 8'h00;
    adrx  = 5'd0;
    adry  = 5'd0;
    rf_wr = 1'b0;

    // Reset read
    tick();
    rst  = 1'b0;
    adrx = 5'd4;
    adry = 5'd31;
    expect_xy(8'h00, 8'h00);
    check_xy("reset_read");

    // Single write to register 5
    adrx  = 5'd5;
    din   = 8'hFF;
    rf_wr = 1'b1;
    tick();
    rf_wr = 1'b0;
    adry  = 5'd3;
    expect_xy(8'hFF, 8'h00);
    check_xy("single_write_y3");
    adry = 5'd5;
    expect_xy(8'hFF, 8'hFF);
    check_xy("single_write_y5");

    // Write enable low leaves register 7 untouched
    adrx  = 5'd7;
    din   = 8'hAA;
    rf_wr = 1'b0;
    expect_xy(8'h00, 8'hFF);
    check_xy("we_low_before");
    tick();
    tick();
    expect_xy(8'h00, 8'hFF);
    check_xy("we_low_after");

    // Fill every register with its index, then sweep both ports
    for (int i = 0; i < 32; i++) begin
      adrx  = 5'(i);
      din   = 8'(i);
      rf_wr = 1'b1;
      tick();
    end
    rf_wr = 1'b0;
    for (int i = 0; i < 32; i++) begin
      adrx = 5'(i);
      adry = 5'(31 - i);
      expect_xy(8'(i), 8'(31 - i));
      check_xy($sformatf("sweep_%0d", i));
    end

    // Read during write on a shared address
    adrx  = 5'd9;
    din   = 8'h11;
    rf_wr = 1'b1;
    tick();
    adry = 5'd9;
    din  = 8'h22;
    expect_xy(8'h11, 8'h11);
    check_xy("rdw_before_edge");
    tick();
    rf_wr = 1'b0;
    expect_xy(8'h22, 8'h22);
    check_xy("rdw_after_edge");

    // Reset takes priority over a same-edge write
    rst   = 1'b1;
    rf_wr = 1'b1;
    adrx  = 5'd2;
    din   = 8'h5A;
    tick();
    rst   = 1'b0;
    rf_wr = 1'b0;
    adry  = 5'd2;
    expect_xy(8'h00, 8'h00);
    check_xy("rst_priority_reg2");
    for (int i = 0; i < 32; i++) begin
      adrx = 5'(i);
      adry = 5'(31 - i);
      expect_xy(8'h00, 8'h00);
      check_xy($sformatf("rst_clear_%0d", i));
    end

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
